seq_divider_n: RTL and testbench
================================

SEQ_DIVIDER_N -- requirements
Module: seq_divider_n

Interface
REQ-001 The block SHALL have parameter W, default 16, giving the operand, quotient and remainder width (W >= 4).
REQ-002 The block SHALL have port C, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port S, input, 1 bit: start request, level-sensitive, held by the requester until F is seen.
REQ-005 The block SHALL have port SG, input, 1 bit: 1 = signed two's-complement operation, 0 = unsigned; sampled at accept.
REQ-006 The block SHALL have port A, input, W bits: dividend, sampled at accept.
REQ-007 The block SHALL have port B, input, W bits: divisor, sampled at accept.
REQ-008 The block SHALL have port Q, output, W bits: quotient.
REQ-009 The block SHALL have port R, output, W bits: remainder.
REQ-010 The block SHALL have port F, output, 1 bit: finished; Q/R/DZ/OV valid while F=1.
REQ-011 The block SHALL have port BSY, output, 1 bit: high in RUN.
REQ-012 The block SHALL have port DZ, output, 1 bit: divide-by-zero flag for the last result.
REQ-013 The block SHALL have port OV, output, 1 bit: signed overflow flag (MIN / -1) for the last result.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 In IDLE with S=1, the edge SHALL accept: capture A, B and SG; capture |A| and |B| when signed; load iteration counter = W; go to RUN.
REQ-016 If B=0 at accept, the FSM SHALL go directly to DONE with Q = all ones, R = A, DZ=1 and OV=0 (F high 1 cycle after accept).
REQ-017 RUN SHALL perform one restoring shift-subtract iteration per cycle, producing one quotient bit per cycle, MSB first.
REQ-018 On the W-th RUN edge the FSM SHALL register the final Q/R (sign-corrected) and go to DONE, so F rises exactly W cycles after the accept edge.
REQ-019 Signed results SHALL truncate toward zero: Q negative iff operand signs differ and |Q| != 0; R takes the sign of A.
REQ-020 Signed A = 2^(W-1) (MIN) with B = -1 SHALL give Q = MIN, R = 0 and OV=1.
REQ-021 In DONE, F SHALL stay 1 while S=1; when S=0 the next edge SHALL return the FSM to IDLE with F=0.
REQ-022 S falling during RUN SHALL be ignored; DONE is still entered, and F lasts exactly 1 cycle.
REQ-023 Changes on A, B or SG after accept SHALL NOT affect the result.
REQ-024 Q, R, DZ and OV SHALL change only on completion and SHALL hold their values through IDLE until the next completion.
REQ-025 A new operation SHALL NOT be accepted until the FSM passes through IDLE; S held high across DONE never retriggers.

Reset
REQ-026 RST=1 at an edge SHALL force state IDLE, Q=0, R=0, F=0, BSY=0, DZ=0, OV=0 and counter 0, taking priority over S.
REQ-027 RST asserted mid-RUN SHALL abort the operation with no partial result visible.

Configuration
REQ-028 With macro SEQ_DIVIDER_SIGNED_EN defined, SG SHALL select signed or unsigned operation as specified above.
REQ-029 Without SEQ_DIVIDER_SIGNED_EN, SG SHALL be ignored, all operations SHALL be unsigned, OV SHALL be tied 0, and no sign-correction logic SHALL exist.

Structure
REQ-030 Package seq_divider_pkg SHALL hold the state enumeration (IDLE, RUN, DONE), the default width constant (16) and the counter-width function (clog2(W+1)).
REQ-031 The combinational iteration SHALL be sub-module seq_div_step (inputs: partial remainder, dividend bit, divisor; outputs: next remainder, quotient bit).

Verification
REQ-032 W=16, SG=1, A=2000, B=45, S=1 -> F after 16 cycles; Q=44, R=20, DZ=0, OV=0.
REQ-033 SG=1: A=2000, B=-45 -> Q=-44, R=20; A=-2000, B=45 -> Q=-44, R=-20; A=-2000, B=-45 -> Q=44, R=-20.
REQ-034 SG=0, A=0xFFFF, B=0x0010 -> Q=0x0FFF, R=0x000F; B=0 -> F 1 cycle after accept, DZ=1, Q=0xFFFF, R=A.
REQ-035 SG=1, A=0x8000, B=0xFFFF -> Q=0x8000, R=0, OV=1; then S held high 5 cycles after F -> F stays 1 and there is no second BSY.
REQ-036 RST pulsed 5 cycles into RUN -> next cycle F=0, BSY=0, Q=0, R=0; a following start with A=100, B=7 -> Q=14, R=2.
REQ-037 Regression at W=8 and W=32 with SEQ_DIVIDER_SIGNED_EN undefined: random unsigned operands match a reference model, and F arrives at latency W.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared state encoding, default width and counter sizing for seq_divider_n
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_W = 16;

    // Counter must hold the value W itself, not just W-1.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// rtl/seq_div_step.sv - one restoring shift-subtract iteration (combinational)
module seq_div_step
    import seq_divider_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] i_rem,
    input  logic         i_bit,
    input  logic [W-1:0] i_div,
    output logic [W-1:0] o_rem,
    output logic         o_q
);

    logic [W:0] w_trial;
    logic [W:0] w_diff;

    // One extra bit holds the borrow: a clear MSB means the trial subtraction fits.
    assign w_trial = {i_rem, i_bit};
    assign w_diff  = w_trial - {1'b0, i_div};
    assign o_q     = ~w_diff[W];
    assign o_rem   = o_q ? w_diff[W-1:0] : w_trial[W-1:0];

endmodule

// File: rtl/seq_divider_n.sv
// rtl/seq_divider_n.sv - sequential restoring divider, one quotient bit per cycle
// Signed operation is enabled by defining SEQ_DIVIDER_SIGNED_EN; otherwise unsigned only.
module seq_divider_n
    import seq_divider_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         C,
    input  logic         RST,
    input  logic         S,
    input  logic         SG,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] Q,
    output logic [W-1:0] R,
    output logic         F,
    output logic         BSY,
    output logic         DZ,
    output logic         OV
);

    localparam int CW = cnt_w(W);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_dvd;
    logic [W-1:0]    r_dvs;
    logic [W-1:0]    r_rem;

    logic [W-1:0]    w_rem;
    logic            w_qbit;
    logic [W-1:0]    w_quo;
    logic [W-1:0]    w_a_abs;
    logic [W-1:0]    w_b_abs;
    logic [W-1:0]    w_q_fin;
    logic [W-1:0]    w_r_fin;

    seq_div_step #(.W(W)) u_step (
        .i_rem (r_rem),
        .i_bit (r_dvd[W-1]),
        .i_div (r_dvs),
        .o_rem (w_rem),
        .o_q   (w_qbit)
    );

    // Dividend bits leave at the top while quotient bits enter at the bottom.
    assign w_quo = {r_dvd[W-2:0], w_qbit};

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic r_qneg;
    logic r_rneg;
    logic r_ov;
    logic w_ov;

    assign w_a_abs = (SG && A[W-1]) ? -A : A;
    assign w_b_abs = (SG && B[W-1]) ? -B : B;
    assign w_ov    = SG && (A == {1'b1, {(W-1){1'b0}}}) && (B == {W{1'b1}});
    // MIN / -1 needs no special path: |MIN| / 1 with equal signs already yields MIN.
    assign w_q_fin = r_qneg ? -w_quo : w_quo;
    assign w_r_fin = r_rneg ? -w_rem : w_rem;
`else
    logic w_unused_sg;

    assign w_unused_sg = SG;
    assign w_a_abs     = A;
    assign w_b_abs     = B;
    assign w_q_fin     = w_quo;
    assign w_r_fin     = w_rem;
    assign OV          = 1'b0;
`endif

    always_ff @(posedge C) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            Q       <= '0;
            R       <= '0;
            F       <= 1'b0;
            BSY     <= 1'b0;
            DZ      <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_ov    <= 1'b0;
            OV      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (S) begin
                        r_dvd <= w_a_abs;
                        r_dvs <= w_b_abs;
                        r_rem <= '0;
                        r_cnt <= CW'(W);
`ifdef SEQ_DIVIDER_SIGNED_EN
                        r_qneg <= SG && (A[W-1] ^ B[W-1]);
                        r_rneg <= SG && A[W-1];
                        r_ov   <= w_ov;
`endif
                        if (B == '0) begin
                            r_state <= DONE;
                            F       <= 1'b1;
                            Q       <= '1;
                            R       <= A;
                            DZ      <= 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
                            OV      <= 1'b0;
`endif
                        end else begin
                            r_state <= RUN;
                            BSY     <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_rem <= w_rem;
                    r_dvd <= w_quo;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state <= DONE;
                        BSY     <= 1'b0;
                        F       <= 1'b1;
                        Q       <= w_q_fin;
                        R       <= w_r_fin;
                        DZ      <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        OV      <= r_ov;
`endif
                    end
                end
                DONE: begin
                    if (!S) begin
                        r_state <= IDLE;
                        F       <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_n.sv
// tb/tb_seq_divider_n.sv - self-checking bench for seq_divider_n (W=16 directed, W=8/32 random unsigned)
module tb_seq_divider_n;
    import seq_divider_pkg::*;

    typedef struct {
        longint unsigned q;
        longint unsigned r;
        bit              dz;
        bit              ov;
    } res_t;

    int n_run  = 0;
    int n_fail = 0;

    logic c = 1'b0;
    always #5 c = ~c;

    logic        rst, s, sg, f, bsy, dz, ov;
    logic [15:0] a, b, q, r;
    logic        s8, sg8, f8, bsy8, dz8, ov8;
    logic [7:0]  a8, b8, q8, r8;
    logic        s32, sg32, f32, bsy32, dz32, ov32;
    logic [31:0] a32, b32, q32, r32;

    seq_divider_n #(.W(16)) u16 (.C(c), .RST(rst), .S(s), .SG(sg), .A(a), .B(b),
        .Q(q), .R(r), .F(f), .BSY(bsy), .DZ(dz), .OV(ov));
    seq_divider_n #(.W(8)) u8 (.C(c), .RST(rst), .S(s8), .SG(sg8), .A(a8), .B(b8),
        .Q(q8), .R(r8), .F(f8), .BSY(bsy8), .DZ(dz8), .OV(ov8));
    seq_divider_n #(.W(32)) u32 (.C(c), .RST(rst), .S(s32), .SG(sg32), .A(a32), .B(b32),
        .Q(q32), .R(r32), .F(f32), .BSY(bsy32), .DZ(dz32), .OV(ov32));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input bit sgn_req, input longint unsigned av,
                                   input longint unsigned bv, input int w);
        res_t            o;
        longint unsigned mask;
        longint          sa, sb, minv;
        bit              sgn;
        mask = (64'd1 << w) - 64'd1;
`ifdef SEQ_DIVIDER_SIGNED_EN
        sgn = sgn_req;
`else
        sgn = 1'b0;
`endif
        o = '{q: 0, r: 0, dz: 1'b0, ov: 1'b0};
        if (bv == 0) begin
            o.q  = mask;
            o.r  = av;
            o.dz = 1'b1;
        end else if (sgn) begin
            sa   = av << (64 - w);
            sa   = sa >>> (64 - w);
            sb   = bv << (64 - w);
            sb   = sb >>> (64 - w);
            minv = -(longint'(1) << (w - 1));
            if (sa == minv && sb == -1) begin
                o.q  = av;
                o.r  = 0;
                o.ov = 1'b1;
            end else begin
                o.q = longint'(sa / sb) & mask;
                o.r = longint'(sa % sb) & mask;
            end
        end else begin
            o.q = av / bv;
            o.r = av % bv;
        end
        return o;
    endfunction

    res_t pend;
    res_t hold;
    bit   chk_en = 1'b0;

    // Outputs must equal the pending result while F is high and the last result otherwise.
    always @(negedge c) begin
        if (!rst && chk_en) begin
            if (f) begin
                chk("done_q", q, pend.q);
                chk("done_r", r, pend.r);
                chk("done_dz", dz, pend.dz);
                chk("done_ov", ov, pend.ov);
                hold = pend;
            end else begin
                chk("hold_q", q, hold.q);
                chk("hold_r", r, hold.r);
                chk("hold_dz", dz, hold.dz);
                chk("hold_ov", ov, hold.ov);
            end
        end
    end

    task automatic op16(input bit sg_i, input logic [15:0] a_i, input logic [15:0] b_i,
                        input int hold_cyc, input int drop_at);
        int n;
        s    = 1'b1;
        sg   = sg_i;
        a    = a_i;
        b    = b_i;
        pend = model(sg_i, a_i, b_i, 16);
        @(posedge c); #1;
        a  = ~a_i;
        b  = b_i + 16'd1;
        sg = ~sg_i;
        n  = 0;
        while (!f && n < 40) begin
            chk("busy_in_run", bsy, 1'b1);
            @(posedge c); #1;
            n++;
            if (n == drop_at) s = 1'b0;
        end
        chk("latency16", n, (b_i == 16'd0) ? 0 : 16);
        chk("bsy_at_done", bsy, 1'b0);
        repeat (hold_cyc) begin
            @(posedge c); #1;
            chk("f_held", f, 1'b1);
            chk("no_rebusy", bsy, 1'b0);
        end
        s = 1'b0;
        @(posedge c); #1;
        chk("f_clear", f, 1'b0);
    endtask

    task automatic rnd8();
        logic [7:0] ai, bi;
        res_t       e;
        int         n;
        for (int i = 0; i < 20; i++) begin
            ai = 8'($urandom);
            bi = (i == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            e  = model(1'b0, ai, bi, 8);
            s8 = 1'b1; a8 = ai; b8 = bi;
            @(posedge c); #1;
            a8 = ~ai; b8 = ~bi;
            n = 0;
            while (!f8 && n < 80) begin @(posedge c); #1; n++; end
            chk("lat8", n, (bi == 8'd0) ? 0 : 8);
            chk("q8", q8, e.q);
            chk("r8", r8, e.r);
            chk("dz8", dz8, e.dz);
            s8 = 1'b0;
            @(posedge c); #1;
        end
    endtask

    task automatic rnd32();
        logic [31:0] ai, bi;
        res_t        e;
        int          n;
        for (int i = 0; i < 20; i++) begin
            ai  = $urandom;
            bi  = (i < 10) ? 32'($urandom_range(1, 1000)) : $urandom;
            e   = model(1'b0, ai, bi, 32);
            s32 = 1'b1; a32 = ai; b32 = bi;
            @(posedge c); #1;
            a32 = ~ai; b32 = ~bi;
            n = 0;
            while (!f32 && n < 80) begin @(posedge c); #1; n++; end
            chk("lat32", n, (bi == 32'd0) ? 0 : 32);
            chk("q32", q32, e.q);
            chk("r32", r32, e.r);
            chk("dz32", dz32, e.dz);
            s32 = 1'b0;
            @(posedge c); #1;
        end
    endtask

    res_t e;

    initial begin
        rst = 1'b1; s = 1'b0; sg = 1'b0; a = '0; b = '0;
        s8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0;
        s32 = 1'b0; sg32 = 1'b0; a32 = '0; b32 = '0;
        hold = '{q: 0, r: 0, dz: 1'b0, ov: 1'b0};
        pend = hold;
        repeat (2) @(posedge c);
        #1 rst = 1'b0;
        chk("rst_q", q, 0);
        chk("rst_r", r, 0);
        chk("rst_f", f, 0);
        chk("rst_bsy", bsy, 0);
        chk("rst_dz", dz, 0);
        chk("rst_ov", ov, 0);
        chk_en = 1'b1;

        e = model(1'b1, 2000, 45, 16);
        chk("model_2000_45_q", e.q, 44);
        chk("model_2000_45_r", e.r, 20);
        e = model(1'b0, 16'hFFFF, 16'h0010, 16);
        chk("model_ffff_10_q", e.q, 16'h0FFF);
        chk("model_ffff_10_r", e.r, 16'h000F);
        e = model(1'b0, 16'h1234, 0, 16);
        chk("model_dz_q", e.q, 16'hFFFF);
        chk("model_dz_r", e.r, 16'h1234);
`ifdef SEQ_DIVIDER_SIGNED_EN
        e = model(1'b1, 16'hF830, 45, 16);
        chk("model_neg_q", e.q, 16'hFFD4);
        chk("model_neg_r", e.r, 16'hFFEC);
        e = model(1'b1, 16'h8000, 16'hFFFF, 16);
        chk("model_ov", e.ov, 1'b1);
`endif

        op16(1'b1, 16'd2000, 16'd45, 0, 0);
        chk("dut_2000_45_q", q, 44);
        chk("dut_2000_45_r", r, 20);
        op16(1'b1, 16'd2000, 16'hFFD3, 0, 0);
`ifdef SEQ_DIVIDER_SIGNED_EN
        chk("dut_pos_neg_q", q, 16'hFFD4);
        chk("dut_pos_neg_r", r, 16'd20);
`endif
        op16(1'b1, 16'hF830, 16'd45, 0, 0);
`ifdef SEQ_DIVIDER_SIGNED_EN
        chk("dut_neg_pos_q", q, 16'hFFD4);
        chk("dut_neg_pos_r", r, 16'hFFEC);
`endif
        op16(1'b1, 16'hF830, 16'hFFD3, 0, 0);
`ifdef SEQ_DIVIDER_SIGNED_EN
        chk("dut_neg_neg_q", q, 16'd44);
        chk("dut_neg_neg_r", r, 16'hFFEC);
`endif
        op16(1'b0, 16'hFFFF, 16'h0010, 0, 0);
        chk("dut_ffff_10_q", q, 16'h0FFF);
        chk("dut_ffff_10_r", r, 16'h000F);
        op16(1'b0, 16'hABCD, 16'h0000, 0, 0);
        chk("dut_dz_q", q, 16'hFFFF);
        chk("dut_dz_r", r, 16'hABCD);
        chk("dut_dz_flag", dz, 1'b1);
        op16(1'b1, 16'h8000, 16'hFFFF, 5, 0);
`ifdef SEQ_DIVIDER_SIGNED_EN
        chk("dut_ov_q", q, 16'h8000);
        chk("dut_ov_r", r, 16'h0000);
        chk("dut_ov_flag", ov, 1'b1);
`endif
        op16(1'b0, 16'd1000, 16'd3, 0, 4);
        chk("dut_drop_q", q, 333);
        op16(1'b0, 16'd7, 16'd9, 0, 0);
        op16(1'b0, 16'hFFFF, 16'h0001, 0, 0);
        op16(1'b0, 16'hFFFF, 16'hFFFF, 0, 0);
        op16(1'b1, 16'h7FFF, 16'h8000, 0, 0);

        // Abort mid-run: no partial result may surface.
        s = 1'b1; sg = 1'b0; a = 16'd5000; b = 16'd3;
        @(posedge c); #1;
        repeat (5) @(posedge c);
        #1 rst = 1'b1; s = 1'b0;
        @(posedge c); #1;
        rst  = 1'b0;
        hold = '{q: 0, r: 0, dz: 1'b0, ov: 1'b0};
        chk("abort_f", f, 0);
        chk("abort_bsy", bsy, 0);
        chk("abort_q", q, 0);
        chk("abort_r", r, 0);
        op16(1'b0, 16'd100, 16'd7, 0, 0);
        chk("dut_100_7_q", q, 14);
        chk("dut_100_7_r", r, 2);

        rnd8();
        rnd32();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
